uart_rx_deser: RTL and testbench
================================

# uart_rx_deser

Serial receive front end for the Wishbone UART peripheral. It synchronises the raw `rx` pad input (`io_in[30]`) and detects 8N1 frames at a programmable bit period. It deserialises each frame and presents the byte to the UART register/FIFO stage over a valid/ready handshake. It also reports framing and overrun errors as single-cycle pulses, which the UART stage uses for its status bits and `user_irq`.

## Interface
Parameters:
- `DIV_W`, default 16: width of the bit-period divisor.

Ports:
- `wb_clk_i`  in  1  system clock; the only clock.
- `wb_rst_n`  in  1  reset, synchronous, active-low.
- `en_i`  in  1  receiver enable; when low, the FSM is forced to IDLE.
- `clkdiv_i`  in  `DIV_W`  clocks per bit. Legal values are 4 or more. Latched at start detect.
- `rx_i`  in  1  asynchronous serial input. Idle level is 1.
- `data_o`  out  8  received byte, LSB = first data bit.
- `valid_o`  out  1  `data_o` holds an unconsumed byte.
- `ready_i`  in  1  consumer accepts the byte when `valid_o & ready_i`.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun_o`  out  1  one-cycle pulse: a good byte was dropped because the holding register was full.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
Synchroniser:
- `rx_i` passes through two flops to produce `rx_s`.
- A third flop produces `rx_q`, the previous value of `rx_s`.
- All three flops reset to 1.

Start detection:
- A start is detected on `rx_q==1 && rx_s==0`, i.e. a falling edge only.
- A line held low (break, or the tail of a framing error) never re-triggers a start.

FSM states: IDLE, START, DATA, STOP. Registers: `cnt` (`DIV_W` bits), `bitidx` (3 bits), `div_l` (latched `clkdiv_i`), `shreg` (8 bits).
- **IDLE**: on a falling edge with `en_i=1`, go to START. Set `cnt=0` and `div_l=clkdiv_i`.
- **START**: increment `cnt` each cycle. At `cnt == div_l>>1`:
  - if `rx_s==0`, go to DATA with `cnt=0`, `bitidx=0`;
  - otherwise, go to IDLE (glitch rejected, no error reported).
- **DATA**: at `cnt == div_l-1`:
  - write `shreg[bitidx] = rx_s` and set `cnt=0`;
  - if `bitidx==7`, go to STOP; otherwise `bitidx++`.
  - At all other cycles, `cnt++`.
- **STOP**: at `cnt == div_l-1`, sample `rx_s` and go to IDLE.
  - Sample = 1: deliver `shreg`.
  - Sample = 0: pulse `frame_err_o` for one cycle and discard the byte.

Enable and bit-period rules:
- `en_i=0` in any state forces IDLE on the next clock. A partial frame is discarded with no error pulse.
- A mid-frame change of `clkdiv_i` has no effect on the current frame.

Delivery to the holding register (`data_o`/`valid_o`):
- If `valid_o==0`, or `ready_i==1` in the same cycle: load `data_o`, and `valid_o` is 1 next cycle.
- Otherwise: `data_o` is unchanged and `overrun_o` pulses for one cycle. The new byte is lost and the old byte is kept.
- With no delivery, `valid_o & ready_i` clears `valid_o` next cycle.
- Simultaneous accept and delivery: the new byte is loaded, `valid_o` stays 1, and there is no overrun.

## Timing
Reset values:
- `valid_o=0`, `data_o=8'h00`, `frame_err_o=0`, `overrun_o=0`, `busy_o=0`.
- FSM in IDLE; `cnt`, `bitidx`, `shreg` = 0; synchroniser flops = 1.
- Reset mid-frame aborts the frame, with no error pulse.

Cycle timing, with t0 = the first cycle the FSM is in START:
- Start is validated at t0 + (`div_l`>>1).
- Data bit k is sampled at t0 + (`div_l`>>1) + (k+1)·`div_l`.
- The stop bit is sampled at t0 + (`div_l`>>1) + 9·`div_l`.
- `valid_o`, `frame_err_o` and `overrun_o` change on the following clock edge.
- End-to-end: pin falling edge to `valid_o` rise = (`div_l`>>1) + 9·`div_l` + 4 cycles, +0/−1 depending on edge alignment.

Back-to-back frames:
- The FSM returns to IDLE at mid-stop-bit.
- A falling edge 0.5 bit later is captured, so back-to-back frames are received with no gap.

Outputs:
- All outputs are registered; there is no combinational path from inputs to outputs.
- `ready_i` affects state only at clock edges.

## Test plan
- **Reset/idle**: hold `wb_rst_n=0` for 3 cycles with `rx_i=1` -> all outputs 0, `busy_o=0`. Then 200 idle cycles -> no `valid_o`.
- **Single byte**: `clkdiv_i=16`, send 0xA5 (8N1) with `ready_i=1` -> `valid_o` pulses once with `data_o=8'hA5` at cycle 8+144+4 (±1) after the start edge; no error pulses.
- **Back-to-back + stall**: send 0x00, 0xFF, 0x3C with no gap, `ready_i=0` -> `data_o=8'h00` held; two `overrun_o` pulses at the stop samples of bytes 2 and 3. Raise `ready_i` -> `valid_o` clears.
- **Framing error**: send 0x55 with stop bit = 0, then hold `rx_i=0` for 30 bits -> one `frame_err_o` pulse, no `valid_o`, no further start. Release high and send 0x81 -> `data_o=8'h81`.
- **Glitch/enable**: 3-cycle low pulse at `clkdiv_i=16` -> back to IDLE, no outputs. Drop `en_i` during bit 4 of a frame -> `busy_o` falls next cycle, no `valid_o`. Reset asserted mid-frame -> same result.
- **Simultaneous accept**: `valid_o=1` holding 0x11 and `ready_i` asserted exactly in the delivery cycle of 0x22 -> `data_o=8'h22`, `valid_o` stays 1, `overrun_o=0`. Repeat with `clkdiv_i=4` (minimum) -> correct byte.

Source files
------------

// File: rtl/uart_rx_deser.sv
// 8N1 UART receive front end: synchronises rx_i, deserialises frames at a programmable
// bit period and hands bytes to the register stage over a valid/ready holding register.
module uart_rx_deser #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             en_i,
    input  logic [DIV_W-1:0] clkdiv_i,
    input  logic             rx_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bitidx_q, bitidx_d;
    logic [7:0]       shreg_q, shreg_d;

    logic rx_m_q, rx_s_q, rx_q;
    logic [7:0] data_q;
    logic valid_q, frame_err_q, overrun_q;

    logic start_edge, deliver, stop_bad;
    logic [DIV_W-1:0] half_bit, last_cnt;

    // Falling edge only, so a line parked low never re-arms the receiver.
    assign start_edge = rx_q & ~rx_s_q;
    assign half_bit   = div_q >> 1;
    assign last_cnt   = div_q - DIV_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        deliver  = 1'b0;
        stop_bad = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    div_d   = clkdiv_i;
                end
            end
            StStart: begin
                if (cnt_q == half_bit) begin
                    cnt_d    = '0;
                    bitidx_d = '0;
                    state_d  = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            StData: begin
                if (cnt_q == last_cnt) begin
                    shreg_d[bitidx_q] = rx_s_q;
                    cnt_d             = '0;
                    if (bitidx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bitidx_d = bitidx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            StStop: begin
                // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
                if (cnt_q == last_cnt) begin
                    state_d  = StIdle;
                    deliver  = rx_s_q;
                    stop_bad = ~rx_s_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (!en_i) begin
            state_d  = StIdle;
            deliver  = 1'b0;
            stop_bad = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            rx_m_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_q        <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            div_q       <= '0;
            bitidx_q    <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_m_q      <= rx_i;
            rx_s_q      <= rx_m_q;
            rx_q        <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bitidx_q    <= bitidx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= stop_bad;
            overrun_q   <= 1'b0;
            if (deliver) begin
                // An accept in the delivery cycle frees the slot for the new byte.
                if (!valid_q || ready_i) begin
                    data_q  <= shreg_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: stimulus queues expected bytes and error counts,
// a negedge monitor pops and compares on every accepted byte.
module tb_uart_rx_deser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] clkdiv;
    logic        rx;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    uart_rx_deser #(.DIV_W(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .en_i       (en),
        .clkdiv_i   (clkdiv),
        .rx_i       (rx),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .frame_err_o(frame_err),
        .overrun_o  (overrun),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ferr_cnt = 0, ovr_cnt = 0;
    int ferr_exp = 0, ovr_exp = 0;
    int rise_cyc = -1;
    logic valid_prev = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every handshake must match the oldest outstanding expected byte.
    always @(negedge clk) begin
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got %0h, expected none (cycle %0d)", data, cyc);
            end else begin
                chk("byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (valid && !valid_prev) rise_cyc = cyc;
        valid_prev = valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame, LSB first; leaves the line high afterwards.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int d);
        rx = 1'b0;
        tick(d);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(d);
        end
        rx = stop;
        tick(d);
        rx = 1'b1;
    endtask

    task automatic simul_accept(input int d, input logic [7:0] b1, input logic [7:0] b2);
        ready  = 1'b0;
        clkdiv = 16'(d);
        exp_q.push_back(b1);
        send_frame(b1, 1'b1, d);
        tick(10);
        chk("simul_first_valid", {31'd0, valid}, 32'd1);
        chk("simul_first_data", {24'd0, data}, {24'd0, b1});
        exp_q.push_back(b2);
        fork
            send_frame(b2, 1'b1, d);
            begin
                tick(3 + d / 2 + 9 * d);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        tick(3);
        chk("simul_valid_held", {31'd0, valid}, 32'd1);
        chk("simul_new_data", {24'd0, data}, {24'd0, b2});
        chk("simul_no_overrun", ovr_cnt, ovr_exp);
        ready = 1'b1;
        tick(2);
        ready = 1'b0;
        chk("simul_drained", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        int start_cyc;
        rst_n  = 1'b0;
        en     = 1'b1;
        clkdiv = 16'd16;
        rx     = 1'b1;
        ready  = 1'b0;

        // Reset / idle
        tick(3);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(200);
        chk("idle_valid", {31'd0, valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Single byte with latency check
        ready = 1'b1;
        exp_q.push_back(8'hA5);
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 16);
        tick(10);
        chk("single_latency_ok", {31'd0, (rise_cyc - start_cyc >= 155) &&
                                        (rise_cyc - start_cyc <= 157)}, 32'd1);
        chk("single_ferr", ferr_cnt, ferr_exp);
        chk("single_ovr", ovr_cnt, ovr_exp);

        // Back-to-back with consumer stalled
        ready = 1'b0;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        send_frame(8'h3C, 1'b1, 16);
        ovr_exp += 2;
        tick(10);
        chk("stall_valid", {31'd0, valid}, 32'd1);
        chk("stall_data", {24'd0, data}, 32'h00);
        chk("stall_ovr", ovr_cnt, ovr_exp);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        chk("stall_cleared", {31'd0, valid}, 32'd0);

        // Framing error followed by a held-low line
        ready = 1'b1;
        send_frame(8'h55, 1'b0, 16);
        ferr_exp++;
        rx = 1'b0;
        tick(30 * 16);
        chk("ferr_count", ferr_cnt, ferr_exp);
        chk("ferr_no_restart", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        tick(5);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 16);
        tick(10);
        chk("ferr_recover_data", {24'd0, data}, 32'h81);

        // Glitch rejection
        rx = 1'b0;
        tick(3);
        chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        tick(20);
        chk("glitch_idle", {31'd0, busy}, 32'd0);

        // Enable dropped during bit 4
        fork
            send_frame(8'hC3, 1'b1, 16);
            begin
                tick(3 + 8 + 4 * 16 + 8);
                chk("en_busy_mid", {31'd0, busy}, 32'd1);
                en = 1'b0;
                tick(1);
                chk("en_busy_drop", {31'd0, busy}, 32'd0);
            end
        join
        tick(20);
        en = 1'b1;
        tick(20);
        chk("en_idle_after", {31'd0, busy}, 32'd0);

        // Reset asserted mid-frame
        fork
            send_frame(8'h96, 1'b1, 16);
            begin
                tick(3 + 8 + 4 * 16 + 8);
                chk("rst_busy_mid", {31'd0, busy}, 32'd1);
                rst_n = 1'b0;
                tick(1);
                chk("rst_mid_busy", {31'd0, busy}, 32'd0);
                chk("rst_mid_valid", {31'd0, valid}, 32'd0);
            end
        join
        tick(5);
        rst_n = 1'b1;
        tick(20);
        chk("rst_mid_idle", {31'd0, busy}, 32'd0);

        // Simultaneous accept and delivery
        simul_accept(16, 8'h11, 8'h22);
        simul_accept(4, 8'h11, 8'h22);

        // Randomised frames, random periods, occasional bad stop bits
        ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            int d;
            logic [7:0] b;
            bit good;
            d    = $urandom_range(4, 24);
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            clkdiv = 16'(d);
            if (good) exp_q.push_back(b);
            else ferr_exp++;
            fork
                send_frame(b, good, d);
                begin
                    tick(3 * d);
                    clkdiv = 16'($urandom_range(0, 40));
                end
            join
            tick(good ? $urandom_range(0, d) : $urandom_range(2, d + 2));
        end
        tick(50);

        chk("final_ferr", ferr_cnt, ferr_exp);
        chk("final_ovr", ovr_cnt, ovr_exp);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
